instr_mem_responder: RTL and testbench

- Responder side of the fetch-stage instruction read interface: fetch issues a PC-addressed read request; this block returns the 16-bit instruction after a fixed, parameterised latency.
- Replaces the single-cycle instruction memory so fetch can be verified against a stalling memory.
- Includes a preload write port for programs, a flush input for branch redirects, and error flagging for bad addresses.

---
 rtl/instr_mem_responder.sv | 141 ++++++++++++++
 tb/tb_instr_mem_responder.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_responder.sv
// instr_mem_responder
// Responder side of the fetch-stage instruction read interface. Accepts one
// PC-addressed read at a time and returns the 16-bit instruction word a fixed
// LATENCY cycles later, with a preload write port and a flush for redirects.
// LATENCY must be in 1..15 (the wait counter is 4 bits wide).

module instr_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [15:0] req_addr,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [15:0] resp_data,
  output logic        resp_err,
  input  logic        flush,
  output logic        busy,
  input  logic        ld_en,
  input  logic [15:0] ld_addr,
  input  logic [15:0] ld_data
);

  localparam int          IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] DEPTH_U  = 32'(DEPTH_WORDS);
  localparam logic        DIRECT   = (LATENCY == 1);
  localparam logic [3:0]  CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t           state;
  logic [3:0]       counter;
  logic [IDX_W-1:0] idx_q;
  logic             err_q;

  logic [15:0] mem [DEPTH_WORDS];

  logic             accept;
  logic             req_err;
  logic [IDX_W-1:0] req_idx;
  logic             ld_in_range;
  logic             ld_write;
  logic [IDX_W-1:0] rd_idx;
  logic             rd_err;
  logic             ld_addr_lsb_unused;

  // Word index of a byte address lies inside the array.
  function automatic logic word_in_range(input logic [15:0] a);
    return {17'd0, a[15:1]} < DEPTH_U;
  endfunction

  // Byte addresses: bit 0 selects a byte and is meaningless for preload.
  assign ld_addr_lsb_unused = ld_addr[0];

  // Handshake and request decode. req_ready is also held low while reset is
  // asserted so nothing looks acceptable before the block is running.
  always_comb begin
    req_ready = rst && (state == IDLE || state == RESP) && !ld_en && !flush;
    accept    = req_valid && req_ready;
    req_err   = req_addr[0] | ~word_in_range(req_addr);
    req_idx   = req_addr[IDX_W:1];
    busy      = (state != IDLE);
  end

  // Read port select: a latched request while waiting, otherwise the live
  // request (only used when LATENCY==1 enters RESP on the acceptance edge).
  always_comb begin
    rd_idx = (state == WAIT) ? idx_q : req_idx;
    rd_err = (state == WAIT) ? err_q : req_err;
  end

  // Preload write: only from IDLE, only for in-range words. Since ld_en
  // blocks acceptance, a write never coincides with a read being launched.
  always_comb begin
    ld_in_range = word_in_range(ld_addr);
    ld_write    = rst && ld_en && (state == IDLE) && ld_in_range;
  end

  // Instruction array write port (contents survive reset).
  always_ff @(posedge clk) begin
    if (ld_write) begin
      mem[ld_addr[IDX_W:1]] <= ld_data;
    end
  end

  // Request FSM with registered response outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      counter    <= 4'd0;
      idx_q      <= '0;
      err_q      <= 1'b0;
      resp_valid <= 1'b0;
      resp_data  <= 16'h0000;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE, RESP: begin
          if (accept) begin
            idx_q <= req_idx;
            err_q <= req_err;
            if (DIRECT) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_data  <= rd_err ? 16'h0000 : mem[rd_idx];
              resp_err   <= rd_err;
            end else begin
              counter <= CNT_INIT;
              state   <= WAIT;
            end
          end else begin
            state <= IDLE;
          end
        end
        WAIT: begin
          if (flush) begin
            state <= IDLE;
          end else if (counter == 4'd0) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_data  <= rd_err ? 16'h0000 : mem[rd_idx];
            resp_err   <= rd_err;
          end else begin
            counter <= counter - 4'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_responder.sv
// tb_instr_mem_responder
// Randomised self-checking bench. A behavioural model (plain array of words
// plus the address-error rule) predicts every returned word; latency and pulse
// shape are measured in cycles from the acceptance edge.

module tb_instr_mem_responder;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [15:0] req_addr;
  logic        req_ready;
  logic        resp_valid;
  logic [15:0] resp_data;
  logic        resp_err;
  logic        flush;
  logic        busy;
  logic        ld_en;
  logic [15:0] ld_addr;
  logic [15:0] ld_data;

  int errors = 0;
  int checks = 0;

  logic [15:0] model_mem [DEPTH];
  int          loaded [$];

  always #5 clk = ~clk;

  instr_mem_responder #(
    .DEPTH_WORDS(DEPTH),
    .LATENCY    (LAT)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .resp_valid(resp_valid),
    .resp_data (resp_data),
    .resp_err  (resp_err),
    .flush     (flush),
    .busy      (busy),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data)
  );

  // Model: an address is bad when odd or when its word index is past the end.
  function automatic logic exp_err(input logic [15:0] a);
    return a[0] || (int'(a[15:1]) >= DEPTH);
  endfunction

  function automatic logic [15:0] exp_data(input logic [15:0] a);
    if (exp_err(a)) return 16'h0000;
    return model_mem[int'(a[15:1])];
  endfunction

  // Preload one word from IDLE and record it in the model.
  task automatic do_load(input logic [15:0] a, input logic [15:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
    if (int'(a[15:1]) < DEPTH) begin
      model_mem[int'(a[15:1])] = d;
      loaded.push_back(int'(a[15:1]));
    end
  endtask

  // Issue one read from IDLE; report latency (edges from acceptance, the
  // acceptance edge counting as 1), sampled data/err and pulse width.
  task automatic issue_read(input logic [15:0] a, output int lat,
                            output logic [15:0] d, output logic e, output int width);
    int guard;
    req_valid = 1'b1; req_addr = a;
    #1;
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    if (!resp_valid) begin
      lat = -1; d = 16'hxxxx; e = 1'bx; width = 0;
      return;
    end
    d = resp_data; e = resp_err; width = 0;
    while (resp_valid && width < 50) begin
      width++; @(posedge clk); #1;
    end
    $display("read addr=%h lat=%0d data=%h err=%0b width=%0d", a, lat, d, e, width);
  endtask

  task automatic test_reset();
    rst = 1'b0; req_valid = 1'b1; req_addr = 16'h0010;
    flush = 1'b0; ld_en = 1'b0; ld_addr = 16'h0; ld_data = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
    checks++; if (resp_data !== 16'h0000) begin errors++; $display("FAIL reset_resp_data got=%h exp=0000", resp_data); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_err got=%b exp=0", resp_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got=%b exp=0", req_ready); end
    req_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL post_reset_req_ready got=%b exp=1", req_ready); end
    @(posedge clk); #1;
    $display("reset done");
  endtask

  task automatic test_preload_read();
    int lat; logic [15:0] d; logic e; int w;
    do_load(16'h0010, 16'h1234);
    issue_read(16'h0010, lat, d, e, w);
    checks++; if (lat !== LAT) begin errors++; $display("FAIL preload_latency got=%0d exp=%0d", lat, LAT); end
    checks++; if (d !== 16'h1234) begin errors++; $display("FAIL preload_data got=%h exp=1234", d); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL preload_err got=%b exp=0", e); end
    checks++; if (w !== 1) begin errors++; $display("FAIL preload_pulse_width got=%0d exp=1", w); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] addrs [3];
    int acc_cyc [3]; int resp_cyc [3]; logic [15:0] resp_d [3];
    int k, nresp, cyc, extra; logic acc;
    addrs[0] = 16'h0000; addrs[1] = 16'h0002; addrs[2] = 16'h0004;
    for (int i = 0; i < 3; i++) do_load(addrs[i], 16'($urandom_range(1, 16'hFFFF)));
    k = 0; nresp = 0; cyc = 0;
    req_valid = 1'b1; req_addr = addrs[0];
    #1;
    while (cyc < 60 && nresp < 3) begin
      acc = req_valid && req_ready;
      @(posedge clk); #1; cyc++;
      if (acc) begin
        acc_cyc[k] = cyc; k++;
        if (k < 3) req_addr = addrs[k]; else req_valid = 1'b0;
      end
      if (resp_valid) begin
        resp_cyc[nresp] = cyc; resp_d[nresp] = resp_data; nresp++;
        $display("b2b resp %0d cyc=%0d data=%h", nresp - 1, cyc, resp_data);
      end
    end
    req_valid = 1'b0;
    checks++; if (nresp !== 3) begin errors++; $display("FAIL b2b_count got=%0d exp=3", nresp); end
    for (int i = 0; i < nresp && i < k; i++) begin
      checks++;
      if (resp_cyc[i] !== acc_cyc[i] + LAT - 1) begin
        errors++; $display("FAIL b2b_latency_%0d got=%0d exp=%0d", i, resp_cyc[i], acc_cyc[i] + LAT - 1);
      end
      checks++;
      if (resp_d[i] !== exp_data(addrs[i])) begin
        errors++; $display("FAIL b2b_data_%0d got=%h exp=%h", i, resp_d[i], exp_data(addrs[i]));
      end
      if (i > 0) begin
        checks++;
        if (resp_cyc[i] - resp_cyc[i-1] !== LAT) begin
          errors++; $display("FAIL b2b_spacing_%0d got=%0d exp=%0d", i, resp_cyc[i] - resp_cyc[i-1], LAT);
        end
      end
    end
    extra = 0;
    repeat (3 * LAT) begin
      @(posedge clk); #1;
      if (resp_valid) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL b2b_extra_resp got=%0d exp=0", extra); end
  endtask

  task automatic test_errors();
    logic [15:0] bad [5];
    int lat; logic [15:0] d; logic e; int w;
    bad[0] = 16'h0003; bad[1] = 16'h0800; bad[2] = 16'hFFFF; bad[3] = 16'h0801;
    bad[4] = {5'($urandom), 10'($urandom), 1'b1};
    for (int i = 0; i < 5; i++) begin
      issue_read(bad[i], lat, d, e, w);
      checks++; if (lat !== LAT) begin errors++; $display("FAIL err_latency addr=%h got=%0d exp=%0d", bad[i], lat, LAT); end
      checks++; if (e !== exp_err(bad[i])) begin errors++; $display("FAIL err_flag addr=%h got=%b exp=%b", bad[i], e, exp_err(bad[i])); end
      checks++; if (d !== exp_data(bad[i])) begin errors++; $display("FAIL err_data addr=%h got=%h exp=%h", bad[i], d, exp_data(bad[i])); end
      checks++; if (w !== 1) begin errors++; $display("FAIL err_width addr=%h got=%0d exp=1", bad[i], w); end
    end
  endtask

  task automatic test_flush();
    int lat; logic [15:0] d; logic e; int w; int seen; int guard;
    // Flush while waiting: the request is dropped.
    req_valid = 1'b1; req_addr = 16'h0010;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_busy_wait got=%b exp=1", busy); end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy_fall got=%b exp=0", busy); end
    seen = resp_valid ? 1 : 0;
    repeat (2 * LAT + 2) begin
      @(posedge clk); #1;
      if (resp_valid) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL flush_no_resp got=%0d exp=0", seen); end
    $display("flush in wait: responses seen=%0d", seen);
    issue_read(16'h0010, lat, d, e, w);
    checks++; if (d !== 16'h1234 || lat !== LAT) begin
      errors++; $display("FAIL flush_next_read got=%h/%0d exp=1234/%0d", d, lat, LAT);
    end
    // Flush alongside a live response: response stays, new request blocked.
    req_valid = 1'b1; req_addr = 16'h0010;
    @(posedge clk); #1;
    guard = 0;
    while (!resp_valid && guard < 20) begin
      @(posedge clk); #1; guard++;
    end
    flush = 1'b1;
    #1;
    checks++; if (resp_valid !== 1'b1 || resp_data !== 16'h1234) begin
      errors++; $display("FAIL flush_resp_kept got=%b/%h exp=1/1234", resp_valid, resp_data);
    end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL flush_req_ready got=%b exp=0", req_ready); end
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b0;
    checks++; if (busy !== 1'b0 || resp_valid !== 1'b0) begin
      errors++; $display("FAIL flush_blocks_accept busy=%b valid=%b exp=0/0", busy, resp_valid);
    end
    $display("flush in resp done");
  endtask

  task automatic test_load_interaction();
    int lat; logic [15:0] d; logic e; int w;
    logic [15:0] v1; logic [15:0] v2; logic [15:0] w0;
    v1 = 16'($urandom_range(1, 16'h7FFF));
    v2 = ~v1;
    // ld_en with a pending request in IDLE: the load wins, no acceptance.
    ld_en = 1'b1; ld_addr = 16'h0041; ld_data = v1;
    req_valid = 1'b1; req_addr = 16'h0040;
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL load_req_ready got=%b exp=0", req_ready); end
    @(posedge clk); #1;
    ld_en = 1'b0; req_valid = 1'b0;
    model_mem[32] = v1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL load_no_accept busy=%b exp=0", busy); end
    issue_read(16'h0040, lat, d, e, w);
    checks++; if (d !== exp_data(16'h0040)) begin errors++; $display("FAIL load_readback got=%h exp=%h", d, exp_data(16'h0040)); end
    // ld_en while waiting is ignored.
    req_valid = 1'b1; req_addr = 16'h0040;
    @(posedge clk); #1;
    req_valid = 1'b0;
    ld_en = 1'b1; ld_addr = 16'h0040; ld_data = v2;
    @(posedge clk); #1;
    ld_en = 1'b0;
    w = 0;
    while (!resp_valid && w < 20) begin
      @(posedge clk); #1; w++;
    end
    checks++; if (resp_data !== v1) begin errors++; $display("FAIL load_wait_resp got=%h exp=%h", resp_data, v1); end
    @(posedge clk); #1;
    issue_read(16'h0040, lat, d, e, w);
    checks++; if (d !== exp_data(16'h0040)) begin errors++; $display("FAIL load_wait_ignored got=%h exp=%h", d, exp_data(16'h0040)); end
    // Out-of-range preload must not alias onto a low word.
    w0 = exp_data(16'h0000);
    do_load(16'h0800, ~w0);
    issue_read(16'h0000, lat, d, e, w);
    checks++; if (d !== w0) begin errors++; $display("FAIL load_out_of_range got=%h exp=%h", d, w0); end
  endtask

  task automatic test_random();
    int lat; logic [15:0] d; logic e; int w;
    logic [15:0] a; int mode; int wi;
    do_load(16'h07FE, 16'($urandom));
    for (int n = 0; n < 24; n++) begin
      mode = $urandom_range(0, 3);
      if (mode <= 1) begin
        wi = $urandom_range(0, DEPTH - 1);
        do_load(16'(wi * 2), 16'($urandom));
        a = 16'(wi * 2);
      end else if (mode == 2) begin
        a = 16'(loaded[$urandom_range(0, loaded.size() - 1)] * 2);
      end else if ($urandom_range(0, 1) == 1) begin
        a = 16'($urandom_range(0, 16'hFFFF)) | 16'h0001;
      end else begin
        a = 16'(2 * $urandom_range(DEPTH, 32767));
      end
      issue_read(a, lat, d, e, w);
      checks++;
      if (lat !== LAT || w !== 1 || d !== exp_data(a) || e !== exp_err(a)) begin
        errors++;
        $display("FAIL random_read addr=%h got lat=%0d w=%0d d=%h e=%b exp lat=%0d w=1 d=%h e=%b",
                 a, lat, w, d, e, LAT, exp_data(a), exp_err(a));
      end
    end
  endtask

  task automatic test_async_reset();
    int seen; int guard; int lat; logic [15:0] d; logic e; int w;
    // Reset while waiting.
    req_valid = 1'b1; req_addr = 16'h0010;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL areset_pre_busy got=%b exp=1", busy); end
    #2 rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || resp_valid !== 1'b0 || resp_data !== 16'h0000) begin
      errors++; $display("FAIL areset_wait busy=%b valid=%b data=%h exp=0/0/0000", busy, resp_valid, resp_data);
    end
    #2 rst = 1'b1;
    seen = 0;
    repeat (4 * LAT) begin
      @(posedge clk); #1;
      if (resp_valid) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL areset_no_resp got=%0d exp=0", seen); end
    // Reset while a response is being presented.
    req_valid = 1'b1; req_addr = 16'h0010;
    @(posedge clk); #1;
    req_valid = 1'b0;
    guard = 0;
    while (!resp_valid && guard < 20) begin
      @(posedge clk); #1; guard++;
    end
    #2 rst = 1'b0;
    #1;
    checks++; if (resp_valid !== 1'b0 || resp_err !== 1'b0) begin
      errors++; $display("FAIL areset_resp valid=%b err=%b exp=0/0", resp_valid, resp_err);
    end
    #2 rst = 1'b1;
    @(posedge clk); #1;
    issue_read(16'h0010, lat, d, e, w);
    checks++; if (d !== 16'h1234 || lat !== LAT) begin
      errors++; $display("FAIL areset_recover got=%h/%0d exp=1234/%0d", d, lat, LAT);
    end
    $display("async reset done");
  endtask

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_addr = 16'h0; flush = 1'b0;
    ld_en = 1'b0; ld_addr = 16'h0; ld_data = 16'h0;
    test_reset();
    test_preload_read();
    test_back_to_back();
    test_errors();
    test_flush();
    test_load_interaction();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time limit so the bench always ends.
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "time limit reached");
  end

endmodule
